// File: rtl/regfile_wb_pkg.sv
// Shared constants for the write-back register file slice.
// Consumers: regfile_wb (top) and regfile_read_port.
package regfile_wb_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam int REGS_ADDR_BUS = 5;
    localparam int REGS_DATA_BUS = 32;
    localparam int REGS_NUM      = 32;

    localparam logic [REGS_DATA_BUS-1:0] ZERO_WORD    = '0;
    localparam logic [REGS_ADDR_BUS-1:0] NOP_REG_ADDR = '0;

    localparam int NUM_RD_PORTS = 2;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: disable -> r0 -> (optional WB bypass) -> storage.
// Bypass compiled in with REGFILE_WRITE_BYPASS_EN.
module regfile_read_port
    import regfile_wb_pkg::*;
#(
    parameter int DATA_WIDTH = REGS_DATA_BUS,
    parameter int ADDR_WIDTH = REGS_ADDR_BUS,
    parameter int NUM_REGS   = REGS_NUM
) (
    input  logic                                rd_enable,
    input  logic [ADDR_WIDTH-1:0]               rd_addr,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] storage,
    input  logic                                wb_write_enable,
    input  logic [ADDR_WIDTH-1:0]               wb_write_addr,
    input  logic [DATA_WIDTH-1:0]               wb_write_data,
    output logic [DATA_WIDTH-1:0]               rd_data
);

    localparam logic [ADDR_WIDTH-1:0] R0   = ADDR_WIDTH'(NOP_REG_ADDR);
    localparam logic [DATA_WIDTH-1:0] ZERO = DATA_WIDTH'(ZERO_WORD);

`ifdef REGFILE_WRITE_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = (wb_write_enable == ENABLE) && (wb_write_addr == rd_addr);
`else
    // WB inputs are intentionally ignored; the hazard is resolved upstream.
    logic unused_wb;
    assign unused_wb = ^{wb_write_enable, wb_write_addr, wb_write_data};
`endif

    always_comb begin
        rd_data = ZERO;
        if (rd_enable == DISABLE)
            rd_data = ZERO;
        else if (rd_addr == R0)
            rd_data = ZERO;
`ifdef REGFILE_WRITE_BYPASS_EN
        else if (bypass_hit)
            rd_data = wb_write_data;
`endif
        else
            rd_data = storage[rd_addr];
    end

endmodule

// File: rtl/regfile_wb.sv
// Architectural register file: one synchronous WB write port, two combinational
// ID read ports, r0 hardwired to zero, saturating commit counter.
// Optional write-through forwarding: define REGFILE_WRITE_BYPASS_EN.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int DATA_WIDTH = REGS_DATA_BUS,
    parameter int ADDR_WIDTH = REGS_ADDR_BUS,
    parameter int NUM_REGS   = REGS_NUM
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wb_write_enable,
    input  logic [ADDR_WIDTH-1:0] wb_write_addr,
    input  logic [DATA_WIDTH-1:0] wb_write_data,
    input  logic                  read1_enable,
    input  logic [ADDR_WIDTH-1:0] read1_addr,
    output logic [DATA_WIDTH-1:0] read1_data,
    input  logic                  read2_enable,
    input  logic [ADDR_WIDTH-1:0] read2_addr,
    output logic [DATA_WIDTH-1:0] read2_data,
    output logic [CNT_W-1:0]      write_count
);

    if (NUM_REGS != (1 << ADDR_WIDTH)) begin : g_cfg_err
        $error("regfile_wb: NUM_REGS must equal 2**ADDR_WIDTH");
    end

    localparam logic [ADDR_WIDTH-1:0] R0 = ADDR_WIDTH'(NOP_REG_ADDR);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic                                wr_commit;

    assign wr_commit = (wb_write_enable == ENABLE) && (wb_write_addr != R0);

    // r0 is cleared by reset and never targeted by wr_commit, so it stays zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            regs <= '0;
        else if (wr_commit)
            regs[wb_write_addr] <= wb_write_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            write_count <= '0;
        else if (wr_commit && (write_count != CNT_MAX))
            write_count <= write_count + 1'b1;
    end

    logic [NUM_RD_PORTS-1:0]                 rd_en;
    logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data;

    assign rd_en   = {read2_enable, read1_enable};
    assign rd_addr = {read2_addr, read1_addr};

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        regfile_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .NUM_REGS   (NUM_REGS)
        ) u_rd (
            .rd_enable       (rd_en[p]),
            .rd_addr         (rd_addr[p]),
            .storage         (regs),
            .wb_write_enable (wb_write_enable),
            .wb_write_addr   (wb_write_addr),
            .wb_write_data   (wb_write_data),
            .rd_data         (rd_data[p])
        );
    end

    assign read1_data = rd_data[0];
    assign read2_data = rd_data[1];

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed steps plus randomized traffic
// against an array-based reference model.
module tb_regfile_wb;

    logic        clock;
    logic        reset;
    logic        wb_write_enable;
    logic [4:0]  wb_write_addr;
    logic [31:0] wb_write_data;
    logic        read1_enable;
    logic [4:0]  read1_addr;
    logic [31:0] read1_data;
    logic        read2_enable;
    logic [4:0]  read2_addr;
    logic [31:0] read2_data;
    logic [15:0] write_count;

    regfile_wb dut (
        .clock           (clock),
        .reset           (reset),
        .wb_write_enable (wb_write_enable),
        .wb_write_addr   (wb_write_addr),
        .wb_write_data   (wb_write_data),
        .read1_enable    (read1_enable),
        .read1_addr      (read1_addr),
        .read1_data      (read1_data),
        .read2_enable    (read2_enable),
        .read2_addr      (read2_addr),
        .read2_data      (read2_data),
        .write_count     (write_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: plain array of register values and an integer count.
    logic [31:0] model [32];
    int          model_cnt;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          bypass_on;

    function automatic logic [31:0] exp_read(input logic en, input logic [4:0] a);
        if (!en || a == 5'd0) return 32'd0;
        if (bypass_on && wb_write_enable && wb_write_addr == a) return wb_write_data;
        return model[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reads(input string tag);
        chk({tag, "/rd1"}, read1_data, exp_read(read1_enable, read1_addr));
        chk({tag, "/rd2"}, read2_data, exp_read(read2_enable, read2_addr));
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "/cnt"}, {16'd0, write_count}, 32'(model_cnt));
    endtask

    // Advance one edge; model commits what the DUT sees at that edge.
    task automatic tick();
        @(posedge clock);
        if (reset && wb_write_enable && wb_write_addr != 5'd0) begin
            model[wb_write_addr] = wb_write_data;
            if (model_cnt < 65535) model_cnt++;
        end
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        model_cnt = 0;
    endtask

    task automatic drive_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_write_enable = en;
        wb_write_addr   = a;
        wb_write_data   = d;
    endtask

    task automatic drive_rd(input logic e1, input logic [4:0] a1,
                            input logic e2, input logic [4:0] a2);
        read1_enable = e1; read1_addr = a1;
        read2_enable = e2; read2_addr = a2;
    endtask

    initial begin
`ifdef REGFILE_WRITE_BYPASS_EN
        bypass_on = 1'b1;
`else
        bypass_on = 1'b0;
`endif
        model_clear();
        reset = 1'b0;
        drive_wr(1'b1, 5'd3, 32'hCAFE_0003);
        drive_rd(1'b1, 5'd0, 1'b1, 5'd0);

        // Reset held with writes active: nothing may commit.
        for (int i = 0; i < 3; i++) begin
            drive_wr(1'b1, 5'(i + 1), $urandom);
            tick();
        end
        reset = 1'b1;
        drive_wr(1'b0, 5'd0, 32'd0);
        for (int a = 0; a < 32; a++) begin
            drive_rd(1'b1, 5'(a), 1'b1, 5'(31 - a));
            #1;
            chk($sformatf("reset_r%0d", a), read1_data, 32'd0);
            chk($sformatf("reset_p2_r%0d", 31 - a), read2_data, 32'd0);
        end
        chk_cnt("reset");

        // Basic write / read, port 2 disabled.
        drive_wr(1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        drive_wr(1'b0, 5'd0, 32'd0);
        drive_rd(1'b1, 5'd5, 1'b0, 5'd5);
        #2;
        chk("basic_rd1", read1_data, 32'hDEAD_BEEF);
        chk("basic_rd2_dis", read2_data, 32'd0);
        chk("basic_cnt", {16'd0, write_count}, 32'd1);

        // r0 protection, including a same-cycle read of r0.
        drive_wr(1'b1, 5'd0, 32'h1234_5678);
        drive_rd(1'b1, 5'd0, 1'b1, 5'd0);
        #2;
        chk("r0_same_cycle", read1_data, 32'd0);
        tick();
        drive_wr(1'b0, 5'd0, 32'd0);
        #2;
        chk("r0_after", read2_data, 32'd0);
        chk("r0_cnt", {16'd0, write_count}, 32'd1);

        // Same-cycle read/write of r7: old 1, new 2.
        drive_wr(1'b1, 5'd7, 32'h1);
        tick();
        drive_wr(1'b1, 5'd7, 32'h2);
        drive_rd(1'b1, 5'd7, 1'b1, 5'd7);
        #2;
        chk("rw7_same_rd1", read1_data, bypass_on ? 32'h2 : 32'h1);
        chk("rw7_same_rd2", read2_data, bypass_on ? 32'h2 : 32'h1);
        tick();
        drive_wr(1'b0, 5'd0, 32'd0);
        #2;
        chk("rw7_next", read1_data, 32'h2);
        chk_cnt("rw7");

        // Randomized traffic; reads biased toward the write target.
        for (int c = 0; c < 400; c++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            drive_wr(1'($urandom), wa, $urandom);
            drive_rd(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0) ? wa : 5'($urandom),
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0) ? wa : 5'($urandom));
            #2;
            chk_reads($sformatf("rand%0d", c));
            chk_cnt($sformatf("rand%0d", c));
            tick();
        end

        // Async reset between edges clears storage with no clock edge.
        drive_wr(1'b1, 5'd9, 32'hA5A5_A5A5);
        tick();
        drive_wr(1'b0, 5'd0, 32'd0);
        drive_rd(1'b1, 5'd9, 1'b1, 5'd9);
        #1;
        chk("async_pre", read1_data, 32'hA5A5_A5A5);
        reset = 1'b0;
        model_clear();
        #1;
        chk("async_rd1", read1_data, 32'd0);
        chk("async_rd2", read2_data, 32'd0);
        chk_cnt("async");
        tick();
        reset = 1'b1;
        #1;
        chk("async_after", read1_data, 32'd0);

        // Counter saturation: 65537 committed writes.
        for (int i = 0; i < 65537; i++) begin
            drive_wr(1'b1, 5'($urandom_range(1, 31)), $urandom);
            tick();
            if (i == 65533) chk_cnt("sat_fffe");
        end
        drive_wr(1'b0, 5'd0, 32'd0);
        chk("sat_cnt", {16'd0, write_count}, 32'h0000_FFFF);
        drive_wr(1'b1, 5'd11, 32'h0BAD_F00D);
        tick();
        drive_wr(1'b0, 5'd0, 32'd0);
        drive_rd(1'b1, 5'd11, 1'b1, 5'd0);
        #2;
        chk("sat_hold", {16'd0, write_count}, 32'h0000_FFFF);
        chk_reads("sat_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Architectural integer register file; terminates the write-back protocol that the pipeline buffers carry (write_enable / write_addr / write_data) from MEM/WB.
- Supplies two read ports to the ID stage.
- Synchronous single write port, combinational read ports, register 0 hardwired to zero.
- Sits between the MEM/WB buffer output and the ID-stage operand mux.

Parameters:
- DATA_WIDTH, 32, width of each register and data bus.
- ADDR_WIDTH, 5, register address width.
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- wb_write_enable  input  1  write strobe from the MEM/WB buffer; ENABLE = write.
- wb_write_addr  input  ADDR_WIDTH  destination register.
- wb_write_data  input  DATA_WIDTH  value to store.
- read1_enable  input  1  port 1 read request.
- read1_addr  input  ADDR_WIDTH  port 1 source register.
- read1_data  output  DATA_WIDTH  port 1 operand.
- read2_enable  input  1  port 2 read request.
- read2_addr  input  ADDR_WIDTH  port 2 source register.
- read2_data  output  DATA_WIDTH  port 2 operand.
- write_count  output  16  number of committed writes since reset; saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - All NUM_REGS registers clear to 0.
  - write_count clears to 0.
  - read1_data and read2_data evaluate to 0, because all registers are 0.
  - Reset asserted mid-write aborts the write: the register stays 0.
  - Deassertion is synchronised externally; the block only samples reset as a level.
- Write:
  - On a rising clock edge with reset=1, wb_write_enable=ENABLE and wb_write_addr!=0, the register at wb_write_addr takes wb_write_data.
  - Latency: 1 cycle. The new value is visible from storage in the cycle after the edge.
- Register 0:
  - Writes to address 0 are discarded.
  - Reads of address 0 always return 0.
  - A write to address 0 does not count.
- write_count:
  - Increments by 1 on each committed write (enable set, address nonzero).
  - Saturates at 16'hFFFF and holds there; it does not wrap.
- Reads (combinational, zero latency):
  - If readN_enable=DISABLE, readN_data=0.
  - Else if readN_addr=0, readN_data=0.
  - Else readN_data=storage[readN_addr], subject to the optional bypass below.
- Simultaneous events:
  - Both read ports may address the same register; both return the same value.
  - A read and a write to the same register in the same cycle return the old value unless bypass is compiled in.
- Addressing: no out-of-range case, since NUM_REGS=2**ADDR_WIDTH. A mismatched parameter set is a configuration error and is flagged by an elaboration-time check.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - When readN_enable=ENABLE, readN_addr==wb_write_addr, readN_addr!=0 and wb_write_enable=ENABLE, readN_data=wb_write_data in the same cycle.
  - This is write-through forwarding, which removes the WB→ID hazard.
  - Priority: the disable check first, then address 0, then bypass, then storage.
- Undefined: reads return storage only. The hazard must be handled by the stall or forwarding unit.

Decomposition:
- Shared utility include holds:
  - ENABLE/DISABLE
  - ZERO_WORD
  - NOP_REG_ADDR (0)
  - REGS_ADDR_BUS / REGS_DATA_BUS
  - REGS_NUM
- This block uses those constants rather than literals.
- One natural sub-module, regfile_read_port:
  - Implements the enable / zero / bypass / storage selection for one read port.
  - Instantiated twice.

Test Plan:
- Reset: hold reset=0 with writes active, release, read all 32 addresses on both ports → all 0, write_count=0.
- Basic write/read: write r5=0xDEADBEEF, next cycle read1_addr=5 → 0xDEADBEEF; read2_enable=0 → 0; write_count=1.
- r0 protection: write r0=0x12345678 → read r0 = 0, write_count unchanged.
- Same-cycle read/write of r7 (old 0x1, new 0x2):
  - Without REGFILE_WRITE_BYPASS_EN → 0x1, then 0x2 the next cycle.
  - With it → 0x2 immediately.
  - Bypass is never applied to r0.
- Async reset mid-operation: r9=0xA5A5A5A5, pull reset low between edges → read r9 returns 0 without any clock edge.
- Counter saturation: force 65537 committed writes → write_count=0xFFFF and holds.
